// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register file and its write-port controller.
package regfile_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } wb_state_t;

   localparam int REG_ZERO          = 0;
   localparam int DEF_NUM_REQ       = 3;
   localparam int DEF_ADDRESS_WIDTH = 5;
   localparam int DEF_DATA_WIDTH    = 32;

   // A single requester still needs a 1-bit pointer field.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   input  logic               enable_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PTR_W-1:0]   grant_idx_o,
   output logic               grant_valid_o
);

   int idx;

   always_comb begin
      grant_o       = '0;
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      idx           = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (enable_i && !grant_valid_o && req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_o[idx]  = 1'b1;
            grant_idx_o   = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port controller: clears all registers, then round-robin
// shares the single registered write port among the write-back requesters.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clear_req,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            WE3,
   output logic [ADDRESS_WIDTH-1:0]        AD3,
   output logic [DATA_WIDTH-1:0]           WD3,
   output logic                            init_done
);

   localparam int PW = ptr_width(NUM_REQ);
   localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = {ADDRESS_WIDTH{1'b1}};
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = ADDRESS_WIDTH'(REG_ZERO);

   wb_state_t                state_q;
   logic [ADDRESS_WIDTH-1:0] cnt_q;
   logic [PW-1:0]            ptr_q;
   logic                     we3_q;
   logic [ADDRESS_WIDTH-1:0] ad3_q;
   logic [DATA_WIDTH-1:0]    wd3_q;

   logic [NUM_REQ-1:0]       grant;
   logic [PW-1:0]            grant_idx;
   logic                     grant_valid;
   logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0]    data_arr [NUM_REQ];
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]    sel_data;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // A pending clear suppresses grants so nothing is accepted and then lost.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PW)
   ) u_rr (
      .req_i         (req_valid),
      .ptr_i         (ptr_q),
      .enable_i      ((state_q == RUN) && !clear_req),
      .grant_o       (grant),
      .grant_idx_o   (grant_idx),
      .grant_valid_o (grant_valid)
   );

   assign sel_addr = addr_arr[grant_idx];
   assign sel_data = data_arr[grant_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ptr_q   <= '0;
         we3_q   <= 1'b0;
         ad3_q   <= '0;
         wd3_q   <= '0;
      end else begin
         case (state_q)
            INIT: begin
               we3_q <= 1'b1;
               ad3_q <= cnt_q;
               wd3_q <= '0;
               if (cnt_q == CNT_LAST) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (clear_req) begin
                  state_q <= INIT;
                  cnt_q   <= '0;
                  ptr_q   <= '0;
                  we3_q   <= 1'b0;
               end else if (grant_valid) begin
                  // x0 writes are consumed but never reach the register file.
                  we3_q <= (sel_addr != ADDR_ZERO);
                  if (sel_addr != ADDR_ZERO) begin
                     ad3_q <= sel_addr;
                     wd3_q <= sel_data;
                  end
                  ptr_q <= (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
               end else begin
                  we3_q <= 1'b0;
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

   assign req_ready = grant;
   assign WE3       = we3_q;
   assign AD3       = ad3_q;
   assign WD3       = wd3_q;
   assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, hand sequences, random vs. model.
module tb_regfile_wb_arbiter;

   localparam int NR = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic             clk;
   logic             rst_n;
   logic             clear_req;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             WE3;
   logic [AW-1:0]    AD3;
   logic [DW-1:0]    WD3;
   logic             init_done;

   regfile_wb_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_req (clear_req),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .WE3       (WE3),
      .AD3       (AD3),
      .WD3       (WD3),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: in_run flag, clear counter, pointer and expected port values
   bit          m_run;
   int          m_cnt;
   int          m_ptr;
   bit          m_we;
   int unsigned m_ad;
   int unsigned m_wd;

   typedef struct {
      logic [NR-1:0]    valid;
      logic [NR*AW-1:0] addr;
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    exp_ready;
      logic             exp_we;
      logic [AW-1:0]    exp_ad;
      logic [DW-1:0]    exp_wd;
      logic             chk_ad;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NR*AW-1:0] pa(input int a0, input int a1, input int a2);
      return {AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [NR*DW-1:0] pd(input int unsigned d0, input int unsigned d1,
                                           input int unsigned d2);
      return {DW'(d2), DW'(d1), DW'(d0)};
   endfunction

   task automatic model_reset();
      m_run = 0; m_cnt = 0; m_ptr = 0; m_we = 0; m_ad = 0; m_wd = 0;
   endtask

   function automatic int mgrant(input logic [NR-1:0] v, input logic c);
      if (!m_run || c) return -1;
      for (int k = 0; k < NR; k++) begin
         if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                             input logic [NR*DW-1:0] d, input logic c);
      int g;
      int unsigned ad;
      if (!m_run) begin
         m_we = 1; m_ad = m_cnt; m_wd = 0;
         if (m_cnt == (1 << AW) - 1) begin m_run = 1; m_cnt = 0; end
         else m_cnt++;
      end else if (c) begin
         m_run = 0; m_cnt = 0; m_ptr = 0; m_we = 0;
      end else begin
         g = mgrant(v, c);
         if (g >= 0) begin
            ad = int'(a[g*AW +: AW]);
            if (ad == 0) m_we = 0;
            else begin m_we = 1; m_ad = ad; m_wd = d[g*DW +: DW]; end
            m_ptr = (g + 1) % NR;
         end else m_we = 0;
      end
   endtask

   // Drive at a negedge, sample ready 1ns later, clock once, return at the next negedge.
   task automatic step(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                       input logic [NR*DW-1:0] d, input logic c, output logic [NR-1:0] rdy);
      req_valid = v; req_addr = a; req_data = d; clear_req = c;
      #1;
      rdy = req_ready;
      @(posedge clk);
      model_edge(v, a, d, c);
      @(negedge clk);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_we"}, 64'(WE3), 64'd0);
      chk({tag, "_ad"}, 64'(AD3), 64'd0);
      chk({tag, "_wd"}, 64'(WD3), 64'd0);
      chk({tag, "_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_done"}, 64'(init_done), 64'd0);
   endtask

   logic [NR-1:0]    rdy;
   logic [NR-1:0]    rv;
   logic [NR*AW-1:0] ra;
   logic [NR*DW-1:0] rd;
   logic             rc;
   int               eg;

   initial begin
      rst_n = 1'b0; clear_req = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      model_reset();
      #12;
      chk_zero_outputs("rst");
      req_valid = '1;
      #1;
      chk("rst_ready_valid", 64'(req_ready), 64'd0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 32; i++) begin
         step('1, pa(1, 2, 3), pd(1, 2, 3), 1'b0, rdy);
         chk("init_ready", 64'(rdy), 64'd0);
         chk("init_we", 64'(WE3), 64'd1);
         chk("init_ad", 64'(AD3), 64'(i));
         chk("init_wd", 64'(WD3), 64'd0);
         chk("init_done", 64'(init_done), 64'(i == 31));
      end

      tbl[0]  = '{3'b010, pa(0, 5, 0), pd(0, 32'hDEADBEEF, 0), 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
      tbl[1]  = '{3'b000, pa(0, 0, 0), pd(0, 0, 0), 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1};
      tbl[2]  = '{3'b100, pa(0, 0, 7), pd(0, 0, 32'h77), 3'b100, 1'b1, 5'd7, 32'h77, 1'b1};
      for (int k = 0; k < 6; k++)
         tbl[3+k] = '{3'b111, pa(1, 2, 3), pd(32'h11111111, 32'h22222222, 32'h33333333),
                      NR'(1 << (k % 3)), 1'b1, AW'((k % 3) + 1), 32'h11111111 * ((k % 3) + 1), 1'b1};
      tbl[9]  = '{3'b111, pa(0, 2, 3), pd(32'h1234, 32'h22222222, 32'h33333333), 3'b001, 1'b0, 5'd0, 32'd0, 1'b0};
      tbl[10] = '{3'b111, pa(1, 2, 3), pd(32'h11111111, 32'h22222222, 32'h33333333), 3'b010, 1'b1, 5'd2, 32'h22222222, 1'b1};
      tbl[11] = '{3'b001, pa(1, 0, 0), pd(32'h11111111, 0, 0), 3'b001, 1'b1, 5'd1, 32'h11111111, 1'b1};
      tbl[12] = '{3'b000, pa(0, 0, 0), pd(0, 0, 0), 3'b000, 1'b0, 5'd1, 32'h11111111, 1'b1};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].valid, tbl[i].addr, tbl[i].data, 1'b0, rdy);
         chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(tbl[i].exp_ready));
         chk($sformatf("tbl%0d_we", i), 64'(WE3), 64'(tbl[i].exp_we));
         if (tbl[i].chk_ad) begin
            chk($sformatf("tbl%0d_ad", i), 64'(AD3), 64'(tbl[i].exp_ad));
            chk($sformatf("tbl%0d_wd", i), 64'(WD3), 64'(tbl[i].exp_wd));
         end
      end

      for (int n = 0; n < 400; n++) begin
         rv = NR'($urandom_range(0, 7));
         for (int r = 0; r < NR; r++) begin
            ra[r*AW +: AW] = ($urandom_range(0, 6) == 0) ? '0 : AW'($urandom_range(1, 31));
            rd[r*DW +: DW] = $urandom;
         end
         rc = ($urandom_range(0, 39) == 0);
         eg = mgrant(rv, rc);
         step(rv, ra, rd, rc, rdy);
         chk("rnd_ready", 64'(rdy), (eg < 0) ? 64'd0 : 64'(1 << eg));
         chk("rnd_we", 64'(WE3), 64'(m_we));
         chk("rnd_done", 64'(init_done), 64'(m_run));
         if (m_we) begin
            chk("rnd_ad", 64'(AD3), 64'(m_ad));
            chk("rnd_wd", 64'(WD3), 64'(m_wd));
         end
      end

      for (int n = 0; n < 40 && !m_run; n++) step('0, '0, '0, 1'b0, rdy);
      chk("drain_done", 64'(init_done), 64'd1);

      // clear in RUN with requester 2 waiting; mid-INIT clears are ignored
      step(3'b100, pa(0, 0, 9), pd(0, 0, 32'hCAFE0009), 1'b1, rdy);
      chk("clr_ready", 64'(rdy), 64'd0);
      chk("clr_we", 64'(WE3), 64'd0);
      chk("clr_done", 64'(init_done), 64'd0);
      for (int i = 0; i < 32; i++) begin
         step(3'b100, pa(0, 0, 9), pd(0, 0, 32'hCAFE0009), (i >= 10 && i < 13), rdy);
         chk("clr_init_ready", 64'(rdy), 64'd0);
         chk("clr_init_we", 64'(WE3), 64'd1);
         chk("clr_init_ad", 64'(AD3), 64'(i));
         chk("clr_init_done", 64'(init_done), 64'(i == 31));
      end
      step(3'b100, pa(0, 0, 9), pd(0, 0, 32'hCAFE0009), 1'b0, rdy);
      chk("clr_post_ready", 64'(rdy), 64'b100);
      chk("clr_post_we", 64'(WE3), 64'd1);
      chk("clr_post_ad", 64'(AD3), 64'd9);
      chk("clr_post_wd", 64'(WD3), 64'hCAFE0009);

      // async reset mid-RUN, then again at INIT cnt=10
      #2; rst_n = 1'b0; #1;
      chk_zero_outputs("arst_run");
      @(negedge clk); rst_n = 1'b1; model_reset();
      for (int i = 0; i < 10; i++) step('0, '0, '0, 1'b0, rdy);
      chk("pre_arst_ad", 64'(AD3), 64'd9);
      #2; rst_n = 1'b0; #1;
      chk_zero_outputs("arst_init");
      @(negedge clk); rst_n = 1'b1; model_reset();
      for (int i = 0; i < 3; i++) begin
         step('0, '0, '0, 1'b0, rdy);
         chk("rest_we", 64'(WE3), 64'd1);
         chk("rest_ad", 64'(AD3), 64'(i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
